image_frame_writer: RTL
=======================

Name: image_frame_writer

Overview:
- Sits directly downstream of the image read/processing stage. Consumes its VSYNC/HSYNC-framed stream of two RGB888 pixels per cycle.
- Packs each pixel pair into one 48-bit word in BMP byte order (B,G,R) and generates frame-buffer write strobes and addresses.
- Tracks row/column position, flags framing errors and raises Write_Done when a full WIDTH x HEIGHT frame has been stored.
- Synthesizable replacement for simulation-only output capture.

Parameters:
- WIDTH, 768, pixels per line; must be even, >= 4.
- HEIGHT, 512, lines per frame, >= 2.
- ADDR_W, 18, word-address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT/2.

Ports:
- HCLK  in  1  clock, all logic on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- VSYNC  in  1  frame-start pulse/level from upstream; rising edge arms a new frame.
- HSYNC  in  1  high = pixel pair valid this cycle.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  word address, one word = one pixel pair.
- wr_data  out  48  [7:0]=B0 [15:8]=G0 [23:16]=R0 [31:24]=B1 [39:32]=G1 [47:40]=R1.
- row_idx  out  10  line currently being captured, in arrival order.
- Write_Done  out  1  frame complete, level.
- frame_err  out  1  sticky framing error.

Behaviour:
- Reset values (HRESETn low, async): wr_en=0, wr_addr=0, wr_data=0, row_idx=0, Write_Done=0, frame_err=0. State=IDLE, column-pair counter col_p=0, line base=0.
- VSYNC rising edge: detected with a 1-cycle registered copy of VSYNC.
- States:
  - IDLE -> ARMED on VSYNC rise.
  - ARMED -> CAPTURE on first HSYNC=1.
  - CAPTURE -> DONE when the last pair (row HEIGHT-1, col_p WIDTH/2-1) is accepted.
  - DONE -> ARMED on VSYNC rise.
- VSYNC rise in any state, including mid-frame CAPTURE:
  - clears col_p, row_idx, line base and Write_Done;
  - does not clear frame_err;
  - enters ARMED.
- Acceptance: in ARMED/CAPTURE, each HSYNC=1 cycle accepts one pair.
- Latency: 1 cycle. Accepted at cycle N gives wr_en=1 at N+1, with wr_data and wr_addr = line_base + col_p(N) registered. wr_en=0 on all other cycles.
- Addressing (no multiplier):
  - col_p increments per accepted pair and wraps to 0 after WIDTH/2-1.
  - On wrap, row_idx increments and line_base += WIDTH/2.
- Write_Done: asserts in the same cycle as the final wr_en and holds high until VSYNC rise or reset.
- Framing errors (set frame_err, sticky until reset):
  - HSYNC=1 in IDLE or DONE: pair ignored, no wr_en.
  - HSYNC falls while col_p != 0 (short line): position held. The next HSYNC pair continues at the held col_p.
- Back-to-back lines with zero gap are legal; the wrap and next line's first pair proceed without bubble.
- Simultaneous VSYNC rise and HSYNC=1: VSYNC wins. Counters clear, and the pair is accepted as pair 0 of the new frame, written to address 0 (ROW_FLIP_EN: (HEIGHT-1)*WIDTH/2).

Optional Feature:
- Macro: IMAGE_WRITER_ROW_FLIP_EN.
- Defined: rows are stored bottom-up as in BMP.
  - line_base starts at (HEIGHT-1)*WIDTH/2 and decrements by WIDTH/2 per line.
  - row_idx still counts arrival order.
- Undefined: top-down addressing as described in Behaviour.

Test Plan (WIDTH=8, HEIGHT=4 unless noted):
1. Reset, VSYNC pulse, then 4 lines of 4 HSYNC cycles with 2-cycle gaps. Pair k data R0=k, G0=k+1, B0=k+2 (R1/G1/B1 = +3..+5) -> 16 wr_en pulses at addr 0..15, each 1 cycle after its HSYNC. Word 0 = 0x030405000102. Write_Done rises with addr 15 write. frame_err=0.
2. Same frame with IMAGE_WRITER_ROW_FLIP_EN -> line 0 writes addr 12..15, line 3 writes addr 0..3. row_idx sequence 0,1,2,3.
3. After Write_Done, drive HSYNC=1 for 1 cycle -> no wr_en, frame_err=1, Write_Done stays 1. Next VSYNC rise clears Write_Done; frame_err remains 1.
4. Line 1 with only 2 HSYNC cycles, then gap, then 6 more -> frame_err=1. Addresses continue 6,7,8... with no skip; Write_Done after 16 total pairs.
5. VSYNC rise mid-frame after 9 pairs, coincident with HSYNC=1 -> that pair written to addr 0, row_idx=0, Write_Done=0, frame restarts.
6. Assert HRESETn low mid-line -> all outputs 0 asynchronously. HSYNC after release without VSYNC -> ignored, frame_err=1.

Source files
------------

// File: rtl/image_frame_writer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// image_frame_writer
//
// Purpose:
//   Captures a VSYNC/HSYNC-framed stream of two RGB888 pixels per cycle.
//   Each pixel pair is packed into one 48-bit word in BMP byte order (B,G,R).
//   The block produces frame-buffer write strobes and word addresses, tracks
//   the line being captured, flags framing errors and raises Write_Done once
//   a full WIDTH x HEIGHT frame has been written.
//
// Optional feature (compile-time macro IMAGE_WRITER_ROW_FLIP_EN):
//   When defined, lines are stored bottom-up as BMP expects. The first line
//   goes to word (HEIGHT-1)*WIDTH/2 and each later line sits WIDTH/2 words
//   lower. row_idx still counts lines in arrival order. When undefined,
//   lines are stored top-down starting at word 0.
//
// Ports:
//   HCLK        in   clock, rising edge
//   HRESETn     in   asynchronous active-low reset
//   VSYNC       in   frame start; a rising edge arms a new frame
//   HSYNC       in   pixel pair valid this cycle
//   DATA_R0/G0/B0  in  even pixel
//   DATA_R1/G1/B1  in  odd pixel
//   wr_en       out  frame-buffer write strobe (one cycle per accepted pair)
//   wr_addr     out  word address, one word = one pixel pair
//   wr_data     out  {R1,G1,B1,R0,G0,B0}
//   row_idx     out  line currently being captured (arrival order)
//   Write_Done  out  frame complete, level, cleared by the next VSYNC rise
//   frame_err   out  sticky framing error, cleared only by reset
// ---------------------------------------------------------------------------
module image_frame_writer #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512,
   parameter int ADDR_W = 18
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              VSYNC,
   input  logic              HSYNC,
   input  logic [7:0]        DATA_R0,
   input  logic [7:0]        DATA_G0,
   input  logic [7:0]        DATA_B0,
   input  logic [7:0]        DATA_R1,
   input  logic [7:0]        DATA_G1,
   input  logic [7:0]        DATA_B1,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [47:0]       wr_data,
   output logic [9:0]        row_idx,
   output logic              Write_Done,
   output logic              frame_err
);

   localparam int                PAIRS     = WIDTH / 2;
   localparam int                COL_W     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PAIRS - 1);
   localparam logic [9:0]        ROW_LAST  = 10'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(PAIRS);
`ifdef IMAGE_WRITER_ROW_FLIP_EN
   localparam logic [ADDR_W-1:0] BASE_INIT = ADDR_W'((HEIGHT - 1) * PAIRS);
`else
   localparam logic [ADDR_W-1:0] BASE_INIT = {ADDR_W{1'b0}};
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t              state_r, state_nxt_s;
   logic                vsync_d_r, hsync_d_r;
   logic [COL_W-1:0]    col_p_r, col_eff_s, col_nxt_s;
   logic [9:0]          row_r, row_eff_s, row_nxt_s;
   logic [ADDR_W-1:0]   base_r, base_eff_s, base_nxt_s;
   logic                wr_en_r, done_r, err_r;
   logic [ADDR_W-1:0]   wr_addr_r;
   logic [47:0]         wr_data_r;
   logic                vsync_rise_s, active_s, accept_s, col_end_s, last_s;
   logic                short_s, err_set_s;

   assign vsync_rise_s = VSYNC & ~vsync_d_r;

   // Position decode, acceptance and FSM next state. A VSYNC rise zeroes the
   // effective position first, so a coincident pair lands as pair 0.
   always_comb begin
      col_eff_s   = col_p_r;
      row_eff_s   = row_r;
      base_eff_s  = base_r;
      active_s    = 1'b0;
      accept_s    = 1'b0;
      col_end_s   = 1'b0;
      last_s      = 1'b0;
      col_nxt_s   = col_p_r;
      row_nxt_s   = row_r;
      base_nxt_s  = base_r;
      state_nxt_s = state_r;

      if (vsync_rise_s) begin
         col_eff_s  = {COL_W{1'b0}};
         row_eff_s  = 10'd0;
         base_eff_s = BASE_INIT;
         active_s   = 1'b1;
      end else begin
         case (state_r)
            ST_ARMED, ST_CAPTURE: active_s = 1'b1;
            default:              active_s = 1'b0;
         endcase
      end

      accept_s  = HSYNC & active_s;
      col_end_s = (col_eff_s == COL_LAST);
      last_s    = accept_s & col_end_s & (row_eff_s == ROW_LAST);

      col_nxt_s  = col_eff_s;
      row_nxt_s  = row_eff_s;
      base_nxt_s = base_eff_s;
      if (accept_s) begin
         if (col_end_s) begin
            col_nxt_s = {COL_W{1'b0}};
            // The final pair leaves row/base on the last line.
            if (last_s) begin
               row_nxt_s  = row_eff_s;
               base_nxt_s = base_eff_s;
            end else begin
               row_nxt_s  = row_eff_s + 10'd1;
`ifdef IMAGE_WRITER_ROW_FLIP_EN
               base_nxt_s = base_eff_s - LINE_STEP;
`else
               base_nxt_s = base_eff_s + LINE_STEP;
`endif
            end
         end else begin
            col_nxt_s = col_eff_s + COL_W'(1);
         end
      end else begin
         col_nxt_s = col_eff_s;
      end

      if (last_s) begin
         state_nxt_s = ST_DONE;
      end else if (accept_s) begin
         state_nxt_s = ST_CAPTURE;
      end else if (vsync_rise_s) begin
         state_nxt_s = ST_ARMED;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Short line: HSYNC dropped partway through a line. A VSYNC rise in the
   // same cycle abandons the frame, so it is not counted as a short line.
   assign short_s   = hsync_d_r & ~HSYNC & (col_p_r != {COL_W{1'b0}}) &
                      ~vsync_rise_s & (state_r == ST_CAPTURE);
   assign err_set_s = (HSYNC & ~active_s) | short_s;

   // FSM, position counters and sync edge history
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r   <= ST_IDLE;
         vsync_d_r <= 1'b0;
         hsync_d_r <= 1'b0;
         col_p_r   <= {COL_W{1'b0}};
         row_r     <= 10'd0;
         base_r    <= {ADDR_W{1'b0}};
      end else begin
         state_r   <= state_nxt_s;
         vsync_d_r <= VSYNC;
         hsync_d_r <= HSYNC;
         col_p_r   <= col_nxt_s;
         row_r     <= row_nxt_s;
         base_r    <= base_nxt_s;
      end
   end

   // Registered write port, done level and sticky error flag
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_en_r   <= 1'b0;
         wr_addr_r <= {ADDR_W{1'b0}};
         wr_data_r <= 48'd0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         wr_en_r <= accept_s;
         if (accept_s) begin
            wr_addr_r <= base_eff_s + ADDR_W'(col_eff_s);
            wr_data_r <= {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
         end else begin
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
         end
         if (vsync_rise_s) begin
            done_r <= 1'b0;
         end else if (last_s) begin
            done_r <= 1'b1;
         end else begin
            done_r <= done_r;
         end
         if (err_set_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end

   assign wr_en      = wr_en_r;
   assign wr_addr    = wr_addr_r;
   assign wr_data    = wr_data_r;
   assign row_idx    = row_r;
   assign Write_Done = done_r;
   assign frame_err  = err_r;

endmodule
